// File: rtl/fpu_add_align.sv
// FP32 add/sub front end: decodes an operand pair, orders it by magnitude and
// aligns the smaller mantissa (with sticky) ready for the downstream mantissa adder.
module fpu_add_align (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [31:0] i_data_a,
    input  logic [31:0] i_data_b,
    input  logic        i_sub,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [7:0]  o_exp,
    output logic [26:0] o_man_big,
    output logic [26:0] o_man_small,
    output logic        o_sign,
    output logic        o_eff_sub,
    output logic        o_special,
    output logic [31:0] o_special_data
);

    localparam int unsigned EXP_W  = 8;
    localparam int unsigned FRAC_W = 23;
    localparam int unsigned MAN_W  = FRAC_W + 1;
    localparam int unsigned GRS_W  = 3;
    localparam int unsigned ALN_W  = MAN_W + GRS_W;
    localparam int unsigned FP_W   = 32;

    localparam logic [EXP_W-1:0] EXP_MAX = {EXP_W{1'b1}};
    localparam logic [FP_W-1:0]  QNAN    = 32'h7FC0_0000;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic s1_valid_q;
    logic out_valid_q;
    logic s2_adv;
    logic s1_adv;

    always_comb begin
        s2_adv  = !out_valid_q || i_ready;
        s1_adv  = !s1_valid_q || s2_adv;
        o_ready = s1_adv;
    end

    // ------------------------------------------------------------------
    // Stage 1 decode
    // ------------------------------------------------------------------
    logic             sign_a;
    logic             sign_b_eff;
    logic             eff_sub;
    logic [EXP_W-1:0] exp_a;
    logic [EXP_W-1:0] exp_b;
    logic [FRAC_W-1:0] frac_a;
    logic [FRAC_W-1:0] frac_b;
    logic             zero_a;
    logic             zero_b;
    logic             nan_a;
    logic             nan_b;
    logic             inf_a;
    logic             inf_b;
    logic [MAN_W-1:0] man_a;
    logic [MAN_W-1:0] man_b;
    logic             a_big;

    always_comb begin
        sign_a     = i_data_a[31];
        sign_b_eff = i_data_b[31] ^ i_sub;
        eff_sub    = i_data_a[31] ^ i_data_b[31] ^ i_sub;
        exp_a      = i_data_a[30:23];
        exp_b      = i_data_b[30:23];
        frac_a     = i_data_a[22:0];
        frac_b     = i_data_b[22:0];
        zero_a     = (exp_a == '0);
        zero_b     = (exp_b == '0);
        nan_a      = (exp_a == EXP_MAX) && (frac_a != '0);
        nan_b      = (exp_b == EXP_MAX) && (frac_b != '0);
        inf_a      = (exp_a == EXP_MAX) && (frac_a == '0);
        inf_b      = (exp_b == EXP_MAX) && (frac_b == '0);
        // Denormals flush to zero, so compare on the flushed mantissas
        man_a      = zero_a ? '0 : {1'b1, frac_a};
        man_b      = zero_b ? '0 : {1'b1, frac_b};
        a_big      = (exp_a > exp_b) || ((exp_a == exp_b) && (man_a >= man_b));
    end

    logic [EXP_W-1:0] s1_exp_d;
    logic [EXP_W-1:0] s1_exp_q;
    logic [MAN_W-1:0] s1_man_big_d;
    logic [MAN_W-1:0] s1_man_big_q;
    logic [MAN_W-1:0] s1_man_small_d;
    logic [MAN_W-1:0] s1_man_small_q;
    logic [EXP_W-1:0] s1_diff_d;
    logic [EXP_W-1:0] s1_diff_q;
    logic             s1_sign_d;
    logic             s1_sign_q;
    logic             s1_eff_sub_d;
    logic             s1_eff_sub_q;
    logic             s1_special_d;
    logic             s1_special_q;
    logic [FP_W-1:0]  s1_special_data_d;
    logic [FP_W-1:0]  s1_special_data_q;

    // Swap into big/small order and resolve special operands
    always_comb begin
        s1_exp_d          = a_big ? exp_a : exp_b;
        s1_man_big_d      = a_big ? man_a : man_b;
        s1_man_small_d    = a_big ? man_b : man_a;
        s1_diff_d         = s1_exp_d - (a_big ? exp_b : exp_a);
        s1_sign_d         = (zero_a && zero_b) ? (sign_a & sign_b_eff)
                                               : (a_big ? sign_a : sign_b_eff);
        s1_eff_sub_d      = eff_sub;
        s1_special_d      = 1'b0;
        s1_special_data_d = '0;

        if (nan_a || nan_b || (inf_a && inf_b && eff_sub)) begin
            s1_special_d      = 1'b1;
            s1_special_data_d = QNAN;
        end else if (inf_a) begin
            s1_special_d      = 1'b1;
            s1_special_data_d = {sign_a, EXP_MAX, {FRAC_W{1'b0}}};
        end else if (inf_b) begin
            s1_special_d      = 1'b1;
            s1_special_data_d = {sign_b_eff, EXP_MAX, {FRAC_W{1'b0}}};
        end

        if (s1_special_d) begin
            s1_exp_d       = '0;
            s1_man_big_d   = '0;
            s1_man_small_d = '0;
            s1_diff_d      = '0;
            s1_sign_d      = 1'b0;
            s1_eff_sub_d   = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_valid_q        <= 1'b0;
            s1_exp_q          <= '0;
            s1_man_big_q      <= '0;
            s1_man_small_q    <= '0;
            s1_diff_q         <= '0;
            s1_sign_q         <= 1'b0;
            s1_eff_sub_q      <= 1'b0;
            s1_special_q      <= 1'b0;
            s1_special_data_q <= '0;
        end else if (s1_adv) begin
            s1_valid_q <= i_valid;
            if (i_valid) begin
                s1_exp_q          <= s1_exp_d;
                s1_man_big_q      <= s1_man_big_d;
                s1_man_small_q    <= s1_man_small_d;
                s1_diff_q         <= s1_diff_d;
                s1_sign_q         <= s1_sign_d;
                s1_eff_sub_q      <= s1_eff_sub_d;
                s1_special_q      <= s1_special_d;
                s1_special_data_q <= s1_special_data_d;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 alignment shift with sticky
    // ------------------------------------------------------------------
    logic [ALN_W-1:0] small_ext;
    logic [ALN_W-1:0] lost_mask;
    logic [ALN_W-1:0] man_small_sh;

    always_comb begin
        small_ext    = {s1_man_small_q, {GRS_W{1'b0}}};
        lost_mask    = '0;
        man_small_sh = '0;
        if (s1_diff_q >= EXP_W'(ALN_W)) begin
            man_small_sh[0] = |small_ext;
        end else begin
            lost_mask       = ~({ALN_W{1'b1}} << s1_diff_q);
            man_small_sh    = small_ext >> s1_diff_q;
            man_small_sh[0] = man_small_sh[0] | (|(small_ext & lost_mask));
        end
    end

    logic [EXP_W-1:0] out_exp_q;
    logic [ALN_W-1:0] out_man_big_q;
    logic [ALN_W-1:0] out_man_small_q;
    logic             out_sign_q;
    logic             out_eff_sub_q;
    logic             out_special_q;
    logic [FP_W-1:0]  out_special_data_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            out_valid_q        <= 1'b0;
            out_exp_q          <= '0;
            out_man_big_q      <= '0;
            out_man_small_q    <= '0;
            out_sign_q         <= 1'b0;
            out_eff_sub_q      <= 1'b0;
            out_special_q      <= 1'b0;
            out_special_data_q <= '0;
        end else if (s2_adv) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                out_exp_q          <= s1_exp_q;
                out_man_big_q      <= {s1_man_big_q, {GRS_W{1'b0}}};
                out_man_small_q    <= man_small_sh;
                out_sign_q         <= s1_sign_q;
                out_eff_sub_q      <= s1_eff_sub_q;
                out_special_q      <= s1_special_q;
                out_special_data_q <= s1_special_data_q;
            end
        end
    end

    assign o_valid        = out_valid_q;
    assign o_exp          = out_exp_q;
    assign o_man_big      = out_man_big_q;
    assign o_man_small    = out_man_small_q;
    assign o_sign         = out_sign_q;
    assign o_eff_sub      = out_eff_sub_q;
    assign o_special      = out_special_q;
    assign o_special_data = out_special_data_q;

endmodule

// File: tb/tb_fpu_add_align.sv
// Self-checking bench for fpu_add_align: directed vectors, randomized streaming
// with backpressure against a magnitude-level reference model, and reset cases.
module tb_fpu_add_align;

    logic        clk;
    logic        rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_data_a;
    logic [31:0] i_data_b;
    logic        i_sub;
    logic        o_valid;
    logic        i_ready;
    logic [7:0]  o_exp;
    logic [26:0] o_man_big;
    logic [26:0] o_man_small;
    logic        o_sign;
    logic        o_eff_sub;
    logic        o_special;
    logic [31:0] o_special_data;

    typedef struct packed {
        logic [7:0]  exp;
        logic [26:0] mb;
        logic [26:0] ms;
        logic        sign;
        logic        eff_sub;
        logic        special;
        logic [31:0] sdata;
    } res_t;

    int   n_vec;
    int   n_err;
    res_t exp_q[$];

    fpu_add_align dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .i_data_a      (i_data_a),
        .i_data_b      (i_data_b),
        .i_sub         (i_sub),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_exp         (o_exp),
        .o_man_big     (o_man_big),
        .o_man_small   (o_man_small),
        .o_sign        (o_sign),
        .o_eff_sub     (o_eff_sub),
        .o_special     (o_special),
        .o_special_data(o_special_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic res_t dut_res();
        return '{o_exp, o_man_big, o_man_small, o_sign, o_eff_sub, o_special, o_special_data};
    endfunction

    // Reference: values treated as plain numbers (magnitude, scaled mantissa, shift)
    function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic sub);
        res_t   r;
        int     ea, eb, e_big, e_small, d;
        longint fa, fb, mag_a, mag_b, m_big, m_small, sh;
        logic   sa, sb, a_is_big;
        r  = '0;
        sa = a[31];
        sb = b[31] ^ sub;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        fa = longint'(a[22:0]);
        fb = longint'(b[22:0]);
        if ((ea == 255 && fa != 0) || (eb == 255 && fb != 0) ||
            (ea == 255 && eb == 255 && sa != sb)) begin
            r.special = 1'b1;
            r.sdata   = 32'h7FC0_0000;
            return r;
        end
        if (ea == 255) begin
            r.special = 1'b1;
            r.sdata   = {sa, 8'hFF, 23'd0};
            return r;
        end
        if (eb == 255) begin
            r.special = 1'b1;
            r.sdata   = {sb, 8'hFF, 23'd0};
            return r;
        end
        mag_a    = (ea == 0) ? 0 : longint'(a[30:0]);
        mag_b    = (eb == 0) ? 0 : longint'(b[30:0]);
        a_is_big = !(mag_b > mag_a);
        e_big    = a_is_big ? ea : eb;
        e_small  = a_is_big ? eb : ea;
        m_big    = a_is_big ? ((ea == 0) ? 0 : fa + 8388608) : ((eb == 0) ? 0 : fb + 8388608);
        m_small  = a_is_big ? ((eb == 0) ? 0 : fb + 8388608) : ((ea == 0) ? 0 : fa + 8388608);
        m_big    = m_big * 8;
        m_small  = m_small * 8;
        d        = e_big - e_small;
        if (d >= 27) begin
            sh = (m_small != 0) ? 1 : 0;
        end else begin
            sh = m_small / (longint'(1) << d);
            if (sh * (longint'(1) << d) != m_small) sh = sh | 1;
        end
        r.exp     = 8'(e_big);
        r.mb      = 27'(m_big);
        r.ms      = 27'(sh);
        r.eff_sub = sa ^ sb;
        r.sign    = (ea == 0 && eb == 0) ? (sa & sb) : (a_is_big ? sa : sb);
        return r;
    endfunction

    function automatic logic [31:0] rand_fp(input logic [7:0] near);
        logic [31:0] v;
        int          k;
        int          e;
        v = $urandom;
        k = int'($urandom_range(0, 15));
        case (k)
            0: begin
                v[30:23] = 8'd0;
                if (v[0]) v[22:0] = '0;
            end
            1: v[30:0] = {8'hFF, 23'd0};
            2: begin
                v[30:23] = 8'hFF;
                v[0]     = 1'b1;
            end
            3, 4, 5, 6, 7, 8, 9, 10: begin
                e = int'(near) + int'($urandom_range(0, 70)) - 35;
                if (e < 1) e = 1;
                if (e > 254) e = 254;
                v[30:23] = 8'(e);
            end
            default: ;
        endcase
        return v;
    endfunction

    task automatic test_reset();
        rst_n   = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b1;
        i_sub   = 1'b0;
        i_data_a = '0;
        i_data_b = '0;
        repeat (3) @(negedge clk);
        #1;
        n_vec++;
        if ({o_valid, dut_res()} !== 98'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got valid=%0b res=%h, want all zero", o_valid, dut_res());
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_vec++;
        if (o_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_ready: got %0b want 1", o_ready);
        end
    endtask

    task automatic test_directed();
        logic [31:0] ta [10];
        logic [31:0] tb [10];
        logic        ts [10];
        res_t        te [10];
        ta[0] = 32'h3F80_0000; tb[0] = 32'h3F80_0000; ts[0] = 0; te[0] = '{8'h7F, 27'h400_0000, 27'h400_0000, 0, 0, 0, 32'h0};
        ta[1] = 32'h3FC0_0000; tb[1] = 32'h4000_0000; ts[1] = 1; te[1] = '{8'h80, 27'h400_0000, 27'h300_0000, 1, 1, 0, 32'h0};
        ta[2] = 32'h3F80_0000; tb[2] = 32'h3080_0000; ts[2] = 0; te[2] = '{8'h7F, 27'h400_0000, 27'h000_0001, 0, 0, 0, 32'h0};
        ta[3] = 32'h7F80_0000; tb[3] = 32'h7F80_0000; ts[3] = 1; te[3] = '{8'h00, 27'h0, 27'h0, 0, 0, 1, 32'h7FC0_0000};
        ta[4] = 32'h7F80_0000; tb[4] = 32'h3F80_0000; ts[4] = 0; te[4] = '{8'h00, 27'h0, 27'h0, 0, 0, 1, 32'h7F80_0000};
        ta[5] = 32'h8000_0000; tb[5] = 32'h0000_0000; ts[5] = 1; te[5] = '{8'h00, 27'h0, 27'h0, 1, 0, 0, 32'h0};
        ta[6] = 32'h3F80_0000; tb[6] = 32'h7FC0_0001; ts[6] = 0; te[6] = '{8'h00, 27'h0, 27'h0, 0, 0, 1, 32'h7FC0_0000};
        ta[7] = 32'hFF80_0000; tb[7] = 32'h7F80_0000; ts[7] = 0; te[7] = '{8'h00, 27'h0, 27'h0, 0, 0, 1, 32'h7FC0_0000};
        ta[8] = 32'h3F80_0000; tb[8] = 32'h7F80_0000; ts[8] = 1; te[8] = '{8'h00, 27'h0, 27'h0, 0, 0, 1, 32'hFF80_0000};
        ta[9] = 32'h0040_0000; tb[9] = 32'h3F80_0000; ts[9] = 0; te[9] = '{8'h7F, 27'h400_0000, 27'h0, 0, 0, 0, 32'h0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            i_ready  = 1'b1;
            i_valid  = 1'b1;
            i_data_a = ta[i];
            i_data_b = tb[i];
            i_sub    = ts[i];
            @(negedge clk);
            i_valid = 1'b0;
            #1;
            n_vec++;
            if (o_valid !== 1'b0) begin
                n_err++;
                $display("FAIL directed%0d_early: o_valid=%0b after 1 cycle, want 0", i, o_valid);
            end
            @(negedge clk);
            #1;
            n_vec++;
            if ({o_valid, dut_res()} !== {1'b1, te[i]}) begin
                n_err++;
                $display("FAIL directed%0d: got v=%0b %h want v=1 %h", i, o_valid, dut_res(), te[i]);
            end
            @(negedge clk);
            #1;
            n_vec++;
            if (o_valid !== 1'b0) begin
                n_err++;
                $display("FAIL directed%0d_dup: o_valid=%0b, want 0", i, o_valid);
            end
        end
    endtask

    task automatic test_random_stream();
        logic [31:0] pa, pb;
        logic        ps;
        logic        pending;
        logic        held_v;
        res_t        held;
        res_t        want;
        pending = 1'b0;
        held_v  = 1'b0;
        held    = '0;
        pa = '0; pb = '0; ps = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            if (held_v) begin
                n_vec++;
                if ({o_valid, dut_res()} !== {1'b1, held}) begin
                    n_err++;
                    $display("FAIL stall_hold: got v=%0b %h want v=1 %h", o_valid, dut_res(), held);
                end
            end
            if (!pending && ($urandom_range(0, 3) != 0)) begin
                pa = rand_fp(8'($urandom_range(1, 254)));
                pb = rand_fp(pa[30:23]);
                ps = 1'($urandom_range(0, 1));
                pending = 1'b1;
            end
            i_valid  = pending;
            i_data_a = pa;
            i_data_b = pb;
            i_sub    = ps;
            i_ready  = ($urandom_range(0, 3) != 0);
            #1;
            if (o_valid && i_ready) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL stream_extra: unexpected output %h", dut_res());
                end else begin
                    want = exp_q.pop_front();
                    if (dut_res() !== want) begin
                        n_err++;
                        $display("FAIL stream_data: got %h want %h", dut_res(), want);
                    end
                end
            end
            held_v = o_valid && !i_ready;
            held   = dut_res();
            if (i_valid && o_ready) begin
                exp_q.push_back(model(pa, pb, ps));
                pending = 1'b0;
            end
        end
        for (int c = 0; c < 10 && exp_q.size() != 0; c++) begin
            @(negedge clk);
            i_valid = 1'b0;
            i_ready = 1'b1;
            #1;
            if (o_valid) begin
                n_vec++;
                want = exp_q.pop_front();
                if (dut_res() !== want) begin
                    n_err++;
                    $display("FAIL drain_data: got %h want %h", dut_res(), want);
                end
            end
        end
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain_lost: %0d results missing, want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] pa [4];
        logic [31:0] pb [4];
        logic        ps [4];
        int          idx;
        int          got;
        res_t        snap;
        res_t        want;
        for (int k = 0; k < 4; k++) begin
            pa[k] = {1'($urandom_range(0, 1)), 8'($urandom_range(100, 150)), 23'($urandom)};
            pb[k] = {1'($urandom_range(0, 1)), 8'($urandom_range(100, 150)), 23'($urandom)};
            ps[k] = 1'($urandom_range(0, 1));
        end
        idx  = 0;
        snap = '0;
        @(negedge clk);
        i_ready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (c != 0) @(negedge clk);
            i_ready  = 1'b0;
            i_valid  = (idx < 4);
            i_data_a = pa[idx % 4];
            i_data_b = pb[idx % 4];
            i_sub    = ps[idx % 4];
            #1;
            if (c == 3) snap = dut_res();
            if (i_valid && o_ready) begin
                exp_q.push_back(model(pa[idx], pb[idx], ps[idx]));
                idx++;
            end
        end
        n_vec++;
        if (idx != 2) begin
            n_err++;
            $display("FAIL bp_accepted: got %0d want 2", idx);
        end
        n_vec++;
        if (o_ready !== 1'b0) begin
            n_err++;
            $display("FAIL bp_ready: got %0b want 0", o_ready);
        end
        n_vec++;
        if ({o_valid, dut_res()} !== {1'b1, snap}) begin
            n_err++;
            $display("FAIL bp_stable: got v=%0b %h want v=1 %h", o_valid, dut_res(), snap);
        end
        got = 0;
        for (int c = 0; c < 20 && got < 4; c++) begin
            @(negedge clk);
            i_ready  = 1'b1;
            i_valid  = (idx < 4);
            i_data_a = pa[idx % 4];
            i_data_b = pb[idx % 4];
            i_sub    = ps[idx % 4];
            #1;
            if (o_valid) begin
                n_vec++;
                got++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL bp_extra: unexpected output %h", dut_res());
                end else begin
                    want = exp_q.pop_front();
                    if (dut_res() !== want) begin
                        n_err++;
                        $display("FAIL bp_order%0d: got %h want %h", got, dut_res(), want);
                    end
                end
            end
            if (i_valid && o_ready) begin
                exp_q.push_back(model(pa[idx], pb[idx], ps[idx]));
                idx++;
            end
        end
        n_vec++;
        if (got != 4 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL bp_count: got %0d outputs (%0d pending) want 4 (0)", got, exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
        i_valid = 1'b0;
    endtask

    task automatic test_reset_midflight();
        int accepted;
        accepted = 0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            i_ready  = 1'b1;
            i_valid  = 1'b1;
            i_data_a = 32'h3F80_0000 + 32'(c);
            i_data_b = 32'h4000_0000;
            i_sub    = 1'b0;
            #1;
            if (o_ready) accepted++;
        end
        @(negedge clk);
        i_valid = 1'b0;
        #1;
        n_vec++;
        if (accepted != 2 || o_valid !== 1'b1) begin
            n_err++;
            $display("FAIL midflight_setup: accepted=%0d o_valid=%0b want 2 and 1", accepted, o_valid);
        end
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({o_valid, dut_res()} !== 98'd0) begin
            n_err++;
            $display("FAIL midflight_reset: got v=%0b %h want all zero", o_valid, dut_res());
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            n_vec++;
            if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
                n_err++;
                $display("FAIL midflight_stale%0d: o_valid=%0b o_ready=%0b want 0 and 1", c, o_valid, o_ready);
            end
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_directed();
        test_random_stream();
        test_backpressure();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fpu_add_align.md
FPU_ADD_ALIGN -- requirements
Module: fpu_add_align

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed for IEEE-754 single precision.
REQ-002 i_clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 i_rst_n  input  1  asynchronous active-low reset.
REQ-004 i_valid  input  1  upstream operand pair valid.
REQ-005 o_ready  output  1  block can accept an operand pair this cycle.
REQ-006 i_data_a  input  32  operand A, FP32.
REQ-007 i_data_b  input  32  operand B, FP32.
REQ-008 i_sub  input  1  1 = A-B, 0 = A+B.
REQ-009 o_valid  output  1  aligned result valid for the downstream mantissa adder.
REQ-010 i_ready  input  1  downstream accepts the result this cycle.
REQ-011 o_exp  output  8  common (larger) exponent.
REQ-012 o_man_big  output  27  larger-magnitude mantissa: hidden bit at [26], fraction at [25:3], guard/round/sticky at [2:0] (=000).
REQ-013 o_man_small  output  27  smaller mantissa, right-shifted, same format; [0] is sticky.
REQ-014 o_sign  output  1  result sign (sign of the larger-magnitude effective operand).
REQ-015 o_eff_sub  output  1  effective subtraction = signA ^ signB ^ i_sub.
REQ-016 o_special  output  1  result is special; downstream SHALL bypass arithmetic.
REQ-017 o_special_data  output  32  final FP32 result when o_special=1, else 0.

Function
REQ-018 Transfer in: on i_valid && o_ready. Transfer out: on o_valid && i_ready.
REQ-019 Two register stages: S1 = decode, exponent compare, swap, diff; S2 = shift with sticky, outputs. Latency exactly 2 cycles with i_ready=1.
REQ-020 Full throughput of one pair per cycle with i_ready=1; no bubbles inserted.
REQ-021 S2 SHALL advance when !o_valid || i_ready; S1 SHALL advance when !S1_valid || S2 advances; o_ready = S1 advance condition (combinational).
REQ-022 Under stall (o_valid=1, i_ready=0), all outputs SHALL hold stable; no data SHALL be dropped or duplicated.
REQ-023 Exponent 0 (zero/denormal) SHALL flush to zero: hidden bit 0, fraction 0.
REQ-024 B's effective sign = signB ^ i_sub.
REQ-025 Big operand = larger exponent; on equal exponents, larger fraction; on full magnitude tie, A.
REQ-026 diff = exp_big - exp_small (8-bit, unsigned, never negative by REQ-025).
REQ-027 o_man_small = man_small >> diff; [0] SHALL be OR of the shifted-out bits with the shifted [0].
REQ-028 diff >= 27: o_man_small = 27'd1 if small mantissa nonzero, else 0.
REQ-029 Any NaN input, or Inf op Inf with o_eff_sub=1: o_special=1, o_special_data=0x7FC00000.
REQ-030 Otherwise any Inf input: o_special=1, o_special_data = that Inf with its effective sign.
REQ-031 When o_special=1, o_exp, o_man_big, o_man_small, o_sign, o_eff_sub SHALL be 0.
REQ-032 Both operands zero: o_special=0, both mantissas 0, o_exp=0, o_sign = signA & effective signB.

Reset
REQ-033 i_rst_n=0 SHALL asynchronously clear both stage valids and all output registers to 0; o_ready SHALL be 1 from reset release onward.
REQ-034 Reset mid-operation SHALL discard in-flight pairs; no o_valid SHALL appear for them after release.

Verification
REQ-035 A=0x3F800000, B=0x3F800000, sub=0 -> after 2 cycles: o_exp=0x7F, man_big=man_small=0x4000000, eff_sub=0, sign=0.
REQ-036 A=0x3FC00000, B=0x40000000, sub=1 -> o_exp=0x80, man_big=0x4000000, man_small=0x3000000, sign=1, eff_sub=1.
REQ-037 A=0x3F800000, B=0x30800000, sub=0 -> diff=30, man_small=0x0000001 (sticky only), o_exp=0x7F.
REQ-038 A=0x7F800000, B=0x7F800000, sub=1 -> o_special=1, o_special_data=0x7FC00000; A=0x7F800000, B=0x3F800000 -> o_special_data=0x7F800000.
REQ-039 Stream 4 pairs with i_ready=0 -> exactly 2 accepted, o_ready=0, outputs stable; raise i_ready -> all 4 emitted in order, no loss or duplicate.
REQ-040 Assert i_rst_n=0 with 2 pairs in flight -> o_valid=0 immediately; after release, o_ready=1 and no stale outputs.
